// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared DMI constants, tx framer states and CRC-32 helpers
package dmi_pkg;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [15:0] PREAMBLE_WORD = 16'h5555;
    localparam logic [15:0] SFD_WORD      = 16'h55D5;

    // Transmit framer states
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t ST_IDLE = 3'd0;
    localparam tx_state_t ST_PRE  = 3'd1;
    localparam tx_state_t ST_DATA = 3'd2;
    localparam tx_state_t ST_PAD  = 3'd3;
    localparam tx_state_t ST_FCS1 = 3'd4;
    localparam tx_state_t ST_FCS2 = 3'd5;
    localparam tx_state_t ST_IFG  = 3'd6;

    // Bit-reverse a byte: wire order is LSB first, the CRC register is MSB first
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // One 16-bit step of the non-reflected CRC-32; [15:8] is the earlier byte
    function automatic logic [31:0] crc32_step16(input logic [31:0] crc, input logic [15:0] data);
        logic [15:0] d;
        logic [31:0] c;
        d = {rev8(data[15:8]), rev8(data[7:0])};
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/dmi_tx_framer.sv
// rtl/dmi_tx_framer.sv - preamble, payload, pad, FCS and inter-frame gap framer
module dmi_tx_framer
    import dmi_pkg::*;
#(
    parameter int MIN_WORDS  = 30,
    parameter int IFG_CYCLES = 6,
    parameter int PRE_WORDS  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    input  logic        i_last,
    output logic        o_in_ready,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_sof,
    output logic        o_eof,
    input  logic        i_out_ready,
    output logic        o_busy
);

    localparam logic [3:0]  PRE_LAST = 4'(PRE_WORDS - 1);
    // The IDLE cycle and the preamble load cycle complete the gap, so the
    // IFG state itself only waits IFG_CYCLES-2 cycles after the FCS2 transfer.
    localparam logic [3:0]  IFG_LAST = 4'(IFG_CYCLES - 3);
    localparam logic [16:0] MIN_W    = 17'(MIN_WORDS);

    tx_state_t   state;
    logic [31:0] crc;
    logic [15:0] word_cnt;
    logic [3:0]  aux_cnt;

    logic        load_en;
    logic [16:0] cnt_inc;
    logic [15:0] word_cnt_nxt;
    logic [31:0] crc_n;
    logic [15:0] fcs_hi;
    logic [15:0] fcs_lo;

    assign load_en      = !o_valid || i_out_ready;
    assign o_in_ready   = (state == ST_DATA) && load_en;
    assign o_busy       = (state != ST_IDLE);
    assign cnt_inc      = {1'b0, word_cnt} + 17'd1;
    assign word_cnt_nxt = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;
    assign crc_n        = ~crc;
    assign fcs_hi       = {rev8(crc_n[31:24]), rev8(crc_n[23:16])};
    assign fcs_lo       = {rev8(crc_n[15:8]),  rev8(crc_n[7:0])};

    // Frame sequencer: owns state, counters, CRC register and the one-deep output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            crc      <= CRC_INIT;
            word_cnt <= 16'd0;
            aux_cnt  <= 4'd0;
            o_data   <= 16'd0;
            o_valid  <= 1'b0;
            o_sof    <= 1'b0;
            o_eof    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        crc      <= CRC_INIT;
                        word_cnt <= 16'd0;
                        aux_cnt  <= 4'd0;
                        state    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (load_en) begin
                        o_data  <= (aux_cnt == PRE_LAST) ? SFD_WORD : PREAMBLE_WORD;
                        o_valid <= 1'b1;
                        o_sof   <= (aux_cnt == 4'd0);
                        o_eof   <= 1'b0;
                        if (aux_cnt == PRE_LAST) begin
                            aux_cnt <= 4'd0;
                            state   <= ST_DATA;
                        end else begin
                            aux_cnt <= aux_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (load_en) begin
                        o_sof <= 1'b0;
                        o_eof <= 1'b0;
                        if (i_valid) begin
                            o_data   <= i_data;
                            o_valid  <= 1'b1;
                            crc      <= crc32_step16(crc, i_data);
                            word_cnt <= word_cnt_nxt;
                            if (i_last) begin
                                state <= (cnt_inc < MIN_W) ? ST_PAD : ST_FCS1;
                            end
                        end else begin
                            o_valid <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    if (load_en) begin
                        o_data   <= 16'h0000;
                        o_valid  <= 1'b1;
                        o_sof    <= 1'b0;
                        o_eof    <= 1'b0;
                        crc      <= crc32_step16(crc, 16'h0000);
                        word_cnt <= word_cnt_nxt;
                        if (cnt_inc >= MIN_W) begin
                            state <= ST_FCS1;
                        end
                    end
                end
                ST_FCS1: begin
                    if (load_en) begin
                        o_data  <= fcs_hi;
                        o_valid <= 1'b1;
                        o_sof   <= 1'b0;
                        o_eof   <= 1'b0;
                        state   <= ST_FCS2;
                    end
                end
                ST_FCS2: begin
                    if (load_en) begin
                        o_data  <= fcs_lo;
                        o_valid <= 1'b1;
                        o_sof   <= 1'b0;
                        o_eof   <= 1'b1;
                        aux_cnt <= 4'd0;
                        state   <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    if (o_valid) begin
                        if (i_out_ready) begin
                            o_valid <= 1'b0;
                            o_eof   <= 1'b0;
                        end
                    end else if (aux_cnt == IFG_LAST) begin
                        aux_cnt <= 4'd0;
                        state   <= ST_IDLE;
                    end else begin
                        aux_cnt <= aux_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
